result_history_ctrl: RTL and testbench
======================================

# result_history_ctrl

Initiator that drives the calculator's synchronous result memory as an 8-entry circular history of 17-bit results. The ALU side stores each new result, and the display side recalls the k-th most recent result. The block sits between the calculator datapath and the memory's enable/ReadWrite/Address/DataIn/DataOut port. It sequences single-cycle writes and two-cycle reads to match the memory's registered read.

## Interface
Parameters:
- n, 17, data width (matches memory word)
- m, 3, address width
- pow2m, 8, history depth (2^m)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- Store  in  1  store request; accepted only in IDLE
- StoreData  in  n  result to store
- Recall  in  1  recall request; accepted only in IDLE
- RecallIndex  in  m  0 = most recent, 1 = previous, …
- Clear  in  1  empty the history (pointer/count only)
- RecallData  out  n  recalled word, held until next recall completes
- RecallValid  out  1  one-cycle pulse, recall finished
- RecallError  out  1  qualifies RecallValid: index ≥ Count
- Busy  out  1  high in WRITE, READ, WAIT
- Count  out  m+1  stored entries, 0..pow2m
- MemEnable  out  1  to memory enable
- MemReadWrite  out  1  to memory ReadWrite (1 = read, 0 = write)
- MemAddress  out  m  to memory Address
- MemDataOut  out  n  to memory DataIn
- MemDataIn  in  n  from memory DataOut

## Operation
- FSM states: IDLE, WRITE, READ, WAIT.
- IDLE priority: Clear > Store > Recall. Lower-priority requests in the same cycle are dropped, not queued. Requests while Busy are ignored.
- Clear: WrPtr ← 0, Count ← 0. Memory is untouched. Stays IDLE.
- Store: latch StoreData, then go to WRITE.
  - WRITE drives MemEnable=1, MemReadWrite=0, MemAddress=WrPtr, MemDataOut=latched data.
  - At the end of WRITE: WrPtr ← WrPtr+1 mod pow2m, Count ← min(Count+1, pow2m), then IDLE.
  - When Count = pow2m, the oldest entry is overwritten.
- Recall, index < Count: RdAddr ← (WrPtr − 1 − RecallIndex) mod pow2m, then READ.
  - READ drives MemEnable=1, MemReadWrite=1, MemAddress=RdAddr, then WAIT.
  - WAIT drives MemEnable=0, captures MemDataIn into RecallData, pulses RecallValid with RecallError=0, then IDLE.
- Recall, index ≥ Count (including Count=0): no memory access. Next cycle RecallValid=1, RecallError=1, RecallData ← 0. Stays IDLE.
- Outside WRITE/READ: MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataOut=0.
- Mod-pow2m arithmetic is m-bit wraparound. Count saturates and never wraps.

## Timing
- Reset (synchronous, takes priority over everything): state IDLE, WrPtr=0, Count=0, RecallData=0, RecallValid=0, RecallError=0, Busy=0, MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataOut=0.
- Reset mid-operation aborts the operation. A WRITE in progress at the reset edge must not advance WrPtr or Count.
- Store accepted at edge 0: WRITE during cycle 1, memory written at edge 1. Busy high in cycle 1 only. Next request is accepted at edge 1.
- Recall accepted at edge 0: READ in cycle 1, memory registers DataOut at edge 1, WAIT in cycle 2, capture at edge 2. RecallValid high in cycle 3.
  - Busy is high in cycles 1–2.
  - A new request may be accepted at edge 3 (the cycle RecallValid is high).
- Error recall accepted at edge 0: RecallValid/RecallError high in cycle 1. Busy stays low.
- RecallValid and RecallError are registered and never high for more than one cycle.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, WRITE, READ, WAIT);
  - default widths n=17, m=3, pow2m=8, also used by memory and top level;
  - read-direction constant (ReadWrite=1).
- Single flat module; no sub-module needed.
- Integration test instantiates result_history_ctrl wired to the existing memory with matching parameters.

## Test plan
- Reset, then Recall index 0 → RecallValid=1, RecallError=1, RecallData=0 one cycle later. MemEnable never rises.
- Store 17'h00011, 17'h00022, 17'h00033 back-to-back (one per two cycles) → Count=3. Recall 0 returns 17'h00033 three cycles after acceptance. Recall 2 returns 17'h00011.
- Store 10 values 1..10 → Count saturates at 8, WrPtr wrapped to 2. Recall 0 = 10, Recall 7 = 3. Recall 7 accesses address 2 (mod-8 wrap).
- Store and Recall asserted in the same IDLE cycle → only the write occurs (MemReadWrite=0 for one cycle) and no RecallValid. Clear+Store together → Count=0.
- Recall issued while Busy (during WAIT) → ignored. Exactly one RecallValid pulse.
- Reset asserted during WRITE cycle → Count and WrPtr stay 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/result_history_ctrl_pkg.sv
// Shared widths, FSM state encoding and memory direction constant for the
// calculator result history and its memory.
package result_history_ctrl_pkg;

  localparam int unsigned DATA_W = 17;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  // Memory ReadWrite level that selects a read; the write level is its inverse.
  localparam logic MEM_READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/result_history_ctrl.sv
// Circular history of calculator results kept in a synchronous memory:
// single-cycle writes, two-cycle reads matched to the memory's registered DataOut.
module result_history_ctrl
  import result_history_ctrl_pkg::*;
#(
  parameter int unsigned n     = DATA_W,
  parameter int unsigned m     = ADDR_W,
  parameter int unsigned pow2m = DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         Store,
  input  logic [n-1:0] StoreData,
  input  logic         Recall,
  input  logic [m-1:0] RecallIndex,
  input  logic         Clear,
  output logic [n-1:0] RecallData,
  output logic         RecallValid,
  output logic         RecallError,
  output logic         Busy,
  output logic [m:0]   Count,
  output logic         MemEnable,
  output logic         MemReadWrite,
  output logic [m-1:0] MemAddress,
  output logic [n-1:0] MemDataOut,
  input  logic [n-1:0] MemDataIn
);

  state_t       state;
  logic [m-1:0] wr_ptr;
  logic [m-1:0] rd_addr;
  logic         recall_hit;

  // Newest entry sits just below the write pointer; wraparound is the m-bit overflow.
  assign rd_addr    = m'(wr_ptr - m'(1) - RecallIndex);
  assign recall_hit = ((m+1)'(RecallIndex) < Count);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      Count        <= '0;
      RecallData   <= '0;
      RecallValid  <= 1'b0;
      RecallError  <= 1'b0;
      Busy         <= 1'b0;
      MemEnable    <= 1'b0;
      MemReadWrite <= MEM_READ;
      MemAddress   <= '0;
      MemDataOut   <= '0;
    end else begin
      RecallValid <= 1'b0;
      RecallError <= 1'b0;
      case (state)
        IDLE: begin
          if (Clear) begin
            wr_ptr <= '0;
            Count  <= '0;
          end else if (Store) begin
            state        <= WRITE;
            Busy         <= 1'b1;
            MemEnable    <= 1'b1;
            MemReadWrite <= ~MEM_READ;
            MemAddress   <= wr_ptr;
            MemDataOut   <= StoreData;
          end else if (Recall) begin
            if (recall_hit) begin
              state        <= READ;
              Busy         <= 1'b1;
              MemEnable    <= 1'b1;
              MemReadWrite <= MEM_READ;
              MemAddress   <= rd_addr;
            end else begin
              // Out-of-range index answers immediately without touching memory.
              RecallValid <= 1'b1;
              RecallError <= 1'b1;
              RecallData  <= '0;
            end
          end
        end
        WRITE: begin
          wr_ptr <= m'(wr_ptr + m'(1));
          if (Count != (m+1)'(pow2m)) Count <= (m+1)'(Count + (m+1)'(1));
          state        <= IDLE;
          Busy         <= 1'b0;
          MemEnable    <= 1'b0;
          MemReadWrite <= MEM_READ;
          MemAddress   <= '0;
          MemDataOut   <= '0;
        end
        READ: begin
          state      <= WAIT;
          MemEnable  <= 1'b0;
          MemAddress <= '0;
        end
        WAIT: begin
          RecallData  <= MemDataIn;
          RecallValid <= 1'b1;
          state       <= IDLE;
          Busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_history_ctrl.sv
// Self-checking bench for result_history_ctrl: directed vector table, corner
// sequences, and random operations against a queue-based history model.
module tb_result_history_ctrl;

  logic        clock;
  logic        reset;
  logic        Store;
  logic [16:0] StoreData;
  logic        Recall;
  logic [2:0]  RecallIndex;
  logic        Clear;
  logic [16:0] RecallData;
  logic        RecallValid;
  logic        RecallError;
  logic        Busy;
  logic [3:0]  Count;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [2:0]  MemAddress;
  logic [16:0] MemDataOut;
  logic [16:0] MemDataIn;

  result_history_ctrl dut (
    .clock(clock), .reset(reset),
    .Store(Store), .StoreData(StoreData),
    .Recall(Recall), .RecallIndex(RecallIndex), .Clear(Clear),
    .RecallData(RecallData), .RecallValid(RecallValid), .RecallError(RecallError),
    .Busy(Busy), .Count(Count),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
    .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
  );

  // Synchronous memory with registered read, as seen by the controller.
  logic [16:0] mem [8];
  always @(posedge clock) begin
    if (MemEnable) begin
      if (!MemReadWrite) mem[MemAddress] <= MemDataOut;
      else               MemDataIn <= mem[MemAddress];
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: newest result at the front, at most 8 entries.
  int hist [$];
  int ptr_model = 0;

  typedef struct {
    int          op;        // 0 store, 1 recall, 2 clear
    logic [16:0] data;
    logic [2:0]  idx;
    logic [16:0] exp_data;
    bit          exp_err;
    logic [2:0]  exp_addr;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [16:0] d, input logic [2:0] exp_addr,
                          input logic [3:0] exp_count);
    Store = 1'b1; StoreData = d;
    tick();
    Store = 1'b0;
    chk("write_en",    32'(MemEnable), 32'd1);
    chk("write_rw",    32'(MemReadWrite), 32'd0);
    chk("write_addr",  32'(MemAddress), 32'(exp_addr));
    chk("write_data",  32'(MemDataOut), 32'(d));
    chk("write_busy",  32'(Busy), 32'd1);
    tick();
    chk("store_idle_busy", 32'(Busy), 32'd0);
    chk("store_count", 32'(Count), 32'(exp_count));
  endtask

  task automatic do_recall(input logic [2:0] idx, input logic [16:0] exp_data,
                           input bit exp_err, input logic [2:0] exp_addr);
    Recall = 1'b1; RecallIndex = idx;
    tick();
    Recall = 1'b0;
    if (exp_err) begin
      chk("err_valid", 32'(RecallValid), 32'd1);
      chk("err_flag",  32'(RecallError), 32'd1);
      chk("err_data",  32'(RecallData), 32'd0);
      chk("err_memen", 32'(MemEnable), 32'd0);
      chk("err_busy",  32'(Busy), 32'd0);
    end else begin
      chk("read_en",    32'(MemEnable), 32'd1);
      chk("read_rw",    32'(MemReadWrite), 32'd1);
      chk("read_addr",  32'(MemAddress), 32'(exp_addr));
      chk("read_busy",  32'(Busy), 32'd1);
      tick();
      chk("wait_en",    32'(MemEnable), 32'd0);
      chk("wait_busy",  32'(Busy), 32'd1);
      chk("wait_valid", 32'(RecallValid), 32'd0);
      tick();
      chk("rec_valid", 32'(RecallValid), 32'd1);
      chk("rec_err",   32'(RecallError), 32'd0);
      chk("rec_data",  32'(RecallData), 32'(exp_data));
      chk("rec_busy",  32'(Busy), 32'd0);
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clear_count", 32'(Count), 32'd0);
    chk("clear_memen", 32'(MemEnable), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hist.delete();
    ptr_model = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_valid"}, 32'(RecallValid), 32'd0);
    chk({tag, "_err"},   32'(RecallError), 32'd0);
    chk({tag, "_busy"},  32'(Busy), 32'd0);
    chk({tag, "_memen"}, 32'(MemEnable), 32'd0);
    chk({tag, "_rw"},    32'(MemReadWrite), 32'd1);
    chk({tag, "_addr"},  32'(MemAddress), 32'd0);
    chk({tag, "_dout"},  32'(MemDataOut), 32'd0);
  endtask

  // Model-driven operations for the random phase.
  task automatic model_store(input logic [16:0] d);
    logic [2:0] a;
    a = 3'(ptr_model);
    hist.push_front(int'(d));
    if (hist.size() > 8) void'(hist.pop_back());
    ptr_model = (ptr_model + 1) % 8;
    do_store(d, a, 4'(hist.size()));
  endtask

  task automatic model_recall(input int k);
    if (k < hist.size())
      do_recall(3'(k), 17'(hist[k]), 1'b0, 3'(((ptr_model - 1 - k) % 8 + 8) % 8));
    else
      do_recall(3'(k), 17'd0, 1'b1, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b1; Store = 1'b0; StoreData = '0; Recall = 1'b0;
    RecallIndex = '0; Clear = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed table
    vecs.push_back('{1, 17'h0,     3'd0, 17'h0,     1'b1, 3'd0, 4'd0});
    vecs.push_back('{0, 17'h00011, 3'd0, 17'h0,     1'b0, 3'd0, 4'd1});
    vecs.push_back('{0, 17'h00022, 3'd0, 17'h0,     1'b0, 3'd1, 4'd2});
    vecs.push_back('{0, 17'h00033, 3'd0, 17'h0,     1'b0, 3'd2, 4'd3});
    vecs.push_back('{1, 17'h0,     3'd0, 17'h00033, 1'b0, 3'd2, 4'd3});
    vecs.push_back('{1, 17'h0,     3'd2, 17'h00011, 1'b0, 3'd0, 4'd3});
    vecs.push_back('{1, 17'h0,     3'd3, 17'h0,     1'b1, 3'd0, 4'd3});
    vecs.push_back('{2, 17'h0,     3'd0, 17'h0,     1'b0, 3'd0, 4'd0});
    vecs.push_back('{1, 17'h0,     3'd0, 17'h0,     1'b1, 3'd0, 4'd0});
    for (int i = 1; i <= 10; i++)
      vecs.push_back('{0, 17'(i), 3'd0, 17'h0, 1'b0, 3'((i - 1) % 8), 4'(i > 8 ? 8 : i)});
    vecs.push_back('{1, 17'h0,     3'd0, 17'd10,    1'b0, 3'd1, 4'd8});
    vecs.push_back('{1, 17'h0,     3'd7, 17'd3,     1'b0, 3'd2, 4'd8});
    vecs.push_back('{1, 17'h0,     3'd1, 17'd9,     1'b0, 3'd0, 4'd8});

    foreach (vecs[i]) begin
      case (vecs[i].op)
        0: do_store(vecs[i].data, vecs[i].exp_addr, vecs[i].exp_count);
        1: do_recall(vecs[i].idx, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_addr);
        default: do_clear();
      endcase
      chk("vec_count", 32'(Count), 32'(vecs[i].exp_count));
    end

    // Store and Recall together: only the write happens, no recall pulse.
    do_reset();
    Store = 1'b1; Recall = 1'b1; RecallIndex = 3'd0; StoreData = 17'h1abcd;
    tick();
    Store = 1'b0; Recall = 1'b0;
    chk("sr_write_en", 32'(MemEnable), 32'd1);
    chk("sr_write_rw", 32'(MemReadWrite), 32'd0);
    tick();
    chk("sr_rw_back", 32'(MemReadWrite), 32'd1);
    chk("sr_no_valid", 32'(RecallValid), 32'd0);
    tick();
    chk("sr_no_valid2", 32'(RecallValid), 32'd0);
    chk("sr_count", 32'(Count), 32'd1);

    // Clear and Store together: clear wins, no write.
    Clear = 1'b1; Store = 1'b1; StoreData = 17'h00055;
    tick();
    Clear = 1'b0; Store = 1'b0;
    chk("cs_memen", 32'(MemEnable), 32'd0);
    chk("cs_count", 32'(Count), 32'd0);
    tick();
    chk("cs_count2", 32'(Count), 32'd0);

    // Recall during WAIT is ignored: exactly one valid pulse.
    do_store(17'h00077, 3'd0, 4'd1);
    Recall = 1'b1; RecallIndex = 3'd0;
    tick();
    Recall = 1'b0;
    tick();
    Recall = 1'b1;
    tick();
    Recall = 1'b0;
    pulses = int'(RecallValid);
    chk("busy_rec_data", 32'(RecallData), 32'h00077);
    for (int c = 0; c < 4; c++) begin
      tick();
      pulses += int'(RecallValid);
      chk("busy_rec_memen", 32'(MemEnable), 32'd0);
    end
    chk("busy_rec_pulses", 32'(pulses), 32'd1);

    // Reset during WRITE: nothing advances.
    do_reset();
    Store = 1'b1; StoreData = 17'h12345;
    tick();
    Store = 1'b0;
    chk("rw_in_write", 32'(MemEnable), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("rst_write");
    hist.delete();
    ptr_model = 0;
    model_store(17'h00abc);

    // Random operations against the model.
    for (int it = 0; it < 250; it++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op == 0)       begin do_clear(); hist.delete(); ptr_model = 0; end
      else if (op < 10)  model_store(17'($urandom));
      else               model_recall(int'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) tick();
      chk("rand_count", 32'(Count), 32'(hist.size()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
